// File: rtl/cv32e40s_pkg.sv
// Shared PMP CSR types, mode encodings, CSR addresses and small helpers.
package cv32e40s_pkg;

  localparam int PMP_MAX_REGIONS = 16;

  localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
  localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;
  localparam logic [11:0] CSR_MSECCFG  = 12'h747;
  localparam logic [11:0] CSR_MSECCFGH = 12'h757;

  typedef enum logic [1:0] {
    PMP_MODE_OFF   = 2'b00,
    PMP_MODE_TOR   = 2'b01,
    PMP_MODE_NA4   = 2'b10,
    PMP_MODE_NAPOT = 2'b11
  } pmp_cfg_mode_e;

  // One pmpcfg byte: L[7], reserved[6:5], A[4:3], X[2], W[1], R[0]
  typedef struct packed {
    logic          lock;
    logic [1:0]    zero0;
    pmp_cfg_mode_e mode;
    logic          exec;
    logic          write;
    logic          read;
  } pmpncfg_t;

  typedef struct packed {
    logic [28:0] zero0;
    logic        rlb;
    logic        mmwp;
    logic        mml;
  } mseccfg_t;

  typedef struct packed {
    pmpncfg_t [PMP_MAX_REGIONS-1:0]        cfg;
    logic     [PMP_MAX_REGIONS-1:0][33:0]  addr;
    mseccfg_t                              mseccfg;
  } pmp_csr_t;

  // Bits [g-2:0] set: the NAPOT read-back pattern for granularity g.
  function automatic logic [31:0] pmp_napot_ones(input int g);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      m[i] = (i < g - 1);
    end
    return m;
  endfunction

  // Bits [g-1:0] cleared: the OFF/TOR read-back mask for granularity g.
  function automatic logic [31:0] pmp_off_mask(input int g);
    logic [31:0] m;
    m = '1;
    for (int i = 0; i < 32; i++) begin
      m[i] = !(i < g);
    end
    return m;
  endfunction

endpackage

// File: rtl/cv32e40s_pmp_cfg_legalize.sv
// Legalises one pmpcfg write byte: reserved bits, illegal permission
// encodings against the current MML/RLB state, and NA4 folding.
module cv32e40s_pmp_cfg_legalize
  import cv32e40s_pkg::*;
#(
  parameter int PMP_GRANULARITY = 0
) (
  input  logic [7:0] i_wdata,
  input  logic       i_mml,
  input  logic       i_rlb,
  output pmpncfg_t   o_cfg,
  output logic       o_reject
);

  pmpncfg_t w_req;
  logic     w_shared;
  logic     w_mexec;

  assign w_req    = pmpncfg_t'(i_wdata);
  // R=0,W=1 is the shared-region encoding once MML is on
  assign w_shared = !w_req.read && w_req.write;
  assign w_mexec  = w_req.exec && !w_shared;

  // Build the value to store and decide whether the whole byte is dropped
  always_comb begin
    o_cfg       = w_req;
    o_cfg.zero0 = 2'b00;
    if ((PMP_GRANULARITY >= 1) && (w_req.mode == PMP_MODE_NA4)) begin
      o_cfg.mode = PMP_MODE_OFF;
    end
    o_reject = 1'b0;
    if (!i_mml && w_shared) begin
      o_reject = 1'b1;
    end
    if (i_mml && !i_rlb && w_req.lock && (w_mexec || w_shared)) begin
      o_reject = 1'b1;
    end
  end

endmodule

// File: rtl/cv32e40s_pmp_csr.sv
// PMP configuration/address CSRs plus mseccfg, with lock, rule-locking
// bypass and machine-mode-lockdown write filtering.
module cv32e40s_pmp_csr
  import cv32e40s_pkg::*;
#(
  parameter int PMP_GRANULARITY = 0,
  parameter int PMP_NUM_REGIONS = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_we_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic [11:0] csr_raddr_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_wr_ignored_o,
  output pmp_csr_t    csr_pmp_o
);

  localparam logic [31:0] NAPOT_ONES = pmp_napot_ones(PMP_GRANULARITY);
  localparam logic [31:0] OFF_MASK   = pmp_off_mask(PMP_GRANULARITY);

  pmpncfg_t [PMP_MAX_REGIONS-1:0]       w_cfg;
  logic     [PMP_MAX_REGIONS-1:0][31:0] w_addr;
  logic     [PMP_MAX_REGIONS-1:0][31:0] w_addr_rd;
  logic     [PMP_MAX_REGIONS-1:0]       w_locked;
  logic     [PMP_MAX_REGIONS-1:0]       w_lock_bit;
  logic     [PMP_MAX_REGIONS-1:0]       w_cfg_rej;
  logic     [PMP_MAX_REGIONS-1:0]       w_addr_rej;

  logic     r_mml;
  logic     r_mmwp;
  logic     r_rlb;
  logic     r_wr_ignored;
  mseccfg_t w_mseccfg;
  logic     w_any_lock;
  logic     w_msec_we;
  logic     w_rlb_ok;
  logic     w_msec_rej;

  genvar gi;
  generate
    for (gi = 0; gi < PMP_MAX_REGIONS; gi++) begin : g_region
      if (gi < PMP_NUM_REGIONS) begin : g_impl
        pmpncfg_t    r_cfg;
        logic [31:0] r_addr;
        pmpncfg_t    w_legal;
        logic        w_legal_rej;
        logic        w_cfg_we;
        logic        w_addr_we;
        logic        w_addr_lock;

        assign w_cfg_we  = csr_we_i && (csr_waddr_i == (CSR_PMPCFG0 + 12'(gi / 4)));
        assign w_addr_we = csr_we_i && (csr_waddr_i == (CSR_PMPADDR0 + 12'(gi)));

        cv32e40s_pmp_cfg_legalize #(
          .PMP_GRANULARITY (PMP_GRANULARITY)
        ) u_legalize (
          .i_wdata  (csr_wdata_i[8*(gi%4) +: 8]),
          .i_mml    (r_mml),
          .i_rlb    (r_rlb),
          .o_cfg    (w_legal),
          .o_reject (w_legal_rej)
        );

        // The address is also frozen when the next entry is a locked TOR top
        if (gi < PMP_MAX_REGIONS - 1) begin : g_tor
          assign w_addr_lock = w_locked[gi] ||
                               (w_locked[gi+1] && (w_cfg[gi+1].mode == PMP_MODE_TOR));
        end else begin : g_last
          assign w_addr_lock = w_locked[gi];
        end

        assign w_locked[gi]   = r_cfg.lock && !r_rlb;
        assign w_cfg_rej[gi]  = w_cfg_we && (w_locked[gi] || w_legal_rej);
        assign w_addr_rej[gi] = w_addr_we && w_addr_lock;

        // Entry state: accepted cfg byte and address writes, cleared by reset
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            r_cfg  <= '0;
            r_addr <= '0;
          end else begin
            if (w_cfg_we && !w_locked[gi] && !w_legal_rej) begin
              r_cfg <= w_legal;
            end
            if (w_addr_we && !w_addr_lock) begin
              r_addr <= csr_wdata_i;
            end
          end
        end

        assign w_cfg[gi]  = r_cfg;
        assign w_addr[gi] = r_addr;
        // Software view hides sub-granule bits; NA4 only survives at G=0
        assign w_addr_rd[gi] = (r_cfg.mode == PMP_MODE_NAPOT) ? (r_addr | NAPOT_ONES) :
                               (r_cfg.mode == PMP_MODE_NA4)   ? r_addr :
                                                                (r_addr & OFF_MASK);
      end else begin : g_unimpl
        assign w_cfg[gi]      = '0;
        assign w_addr[gi]     = '0;
        assign w_addr_rd[gi]  = '0;
        assign w_locked[gi]   = 1'b0;
        assign w_cfg_rej[gi]  = 1'b0;
        assign w_addr_rej[gi] = 1'b0;
      end
      assign w_lock_bit[gi] = w_cfg[gi].lock;
    end
  endgenerate

  assign w_any_lock = |w_lock_bit;
  assign w_msec_we  = csr_we_i && (csr_waddr_i == CSR_MSECCFG);
  assign w_rlb_ok   = r_rlb || !w_any_lock;
  // Rejected: RLB change while blocked, or an attempt to clear sticky MML/MMWP
  assign w_msec_rej = w_msec_we &&
                      ((!w_rlb_ok && (csr_wdata_i[2] != r_rlb)) ||
                       (r_mml && !csr_wdata_i[0]) ||
                       (r_mmwp && !csr_wdata_i[1]));

  // mseccfg: MML/MMWP only ever set, RLB gated by the lock state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mml  <= 1'b0;
      r_mmwp <= 1'b0;
      r_rlb  <= 1'b0;
    end else if (w_msec_we) begin
      r_mml  <= r_mml | csr_wdata_i[0];
      r_mmwp <= r_mmwp | csr_wdata_i[1];
      if (w_rlb_ok) begin
        r_rlb <= csr_wdata_i[2];
      end
    end
  end

  // One-cycle pulse reporting that the previous write lost some field
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ignored <= 1'b0;
    end else begin
      r_wr_ignored <= (|w_cfg_rej) | (|w_addr_rej) | w_msec_rej;
    end
  end

  assign csr_wr_ignored_o = r_wr_ignored;

  always_comb begin
    w_mseccfg      = '0;
    w_mseccfg.rlb  = r_rlb;
    w_mseccfg.mmwp = r_mmwp;
    w_mseccfg.mml  = r_mml;
  end

  // Combinational read mux from current state; unknown addresses read 0
  always_comb begin
    csr_rdata_o = '0;
    for (int k = 0; k < 4; k++) begin
      if (csr_raddr_i == (CSR_PMPCFG0 + 12'(k))) begin
        csr_rdata_o = w_cfg[4*k +: 4];
      end
    end
    if (csr_raddr_i[11:4] == CSR_PMPADDR0[11:4]) begin
      csr_rdata_o = w_addr_rd[csr_raddr_i[3:0]];
    end
    if (csr_raddr_i == CSR_MSECCFG) begin
      csr_rdata_o = w_mseccfg;
    end
  end

  // Checker-facing view: raw stored values, address widened to 34 bits
  always_comb begin
    csr_pmp_o.cfg     = w_cfg;
    csr_pmp_o.mseccfg = w_mseccfg;
    for (int i = 0; i < PMP_MAX_REGIONS; i++) begin
      csr_pmp_o.addr[i] = {w_addr[i], 2'b00};
    end
  end

endmodule

// File: tb/tb_cv32e40s_pmp_csr.sv
// Bench for cv32e40s_pmp_csr: directed scenarios plus random CSR traffic
// checked every cycle against a rule-level model of the CSR file.
module tb_cv32e40s_pmp_csr;
  import cv32e40s_pkg::*;

  localparam int NR = 4;
  localparam int GR = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csr_we_i = 1'b0;
  logic [11:0] csr_waddr_i = '0;
  logic [31:0] csr_wdata_i = '0;
  logic [11:0] csr_raddr_i = '0;
  logic [31:0] csr_rdata_o;
  logic        csr_wr_ignored_o;
  pmp_csr_t    csr_pmp_o;

  always #5 clk = ~clk;

  cv32e40s_pmp_csr #(
    .PMP_GRANULARITY (GR),
    .PMP_NUM_REGIONS (NR)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .csr_we_i         (csr_we_i),
    .csr_waddr_i      (csr_waddr_i),
    .csr_wdata_i      (csr_wdata_i),
    .csr_raddr_i      (csr_raddr_i),
    .csr_rdata_o      (csr_rdata_o),
    .csr_wr_ignored_o (csr_wr_ignored_o),
    .csr_pmp_o        (csr_pmp_o)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0]  m_cfg  [16];
  logic [31:0] m_addr [16];
  logic        m_mml, m_mmwp, m_rlb, m_ign;
  bit          chk_on = 0;
  logic [31:0] pre_rd;

  task automatic check(input string nm, input logic [543:0] act, input logic [543:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_locked(input int i);
    return m_cfg[i][7] && !m_rlb;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    logic [31:0] v;
    int i;
    v = '0;
    if (a >= 12'h3A0 && a <= 12'h3A3) begin
      for (int b = 0; b < 4; b++) begin
        i = int'(a - 12'h3A0) * 4 + b;
        if (i < NR) v[8*b +: 8] = m_cfg[i];
      end
    end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
      i = int'(a - 12'h3B0);
      if (i < NR) begin
        v = m_addr[i];
        if (m_cfg[i][4:3] == 2'd3) begin
          for (int k = 0; k < GR - 1; k++) v[k] = 1'b1;
        end else if (m_cfg[i][4:3] < 2'd2) begin
          for (int k = 0; k < GR; k++) v[k] = 1'b0;
        end
      end
    end else if (a == 12'h747) begin
      v = {29'd0, m_rlb, m_mmwp, m_mml};
    end
    return v;
  endfunction

  // Apply one clock edge's worth of rules to the model state
  task automatic model_apply(input logic rs, input logic we, input logic [11:0] wa,
                             input logic [31:0] wd);
    logic [7:0]  ncfg [16];
    logic [31:0] naddr [16];
    logic [7:0]  v;
    logic        ign, bad, any_l;
    int          i;
    if (!rs) begin
      for (int k = 0; k < 16; k++) begin
        m_cfg[k] = '0;
        m_addr[k] = '0;
      end
      m_mml = 0; m_mmwp = 0; m_rlb = 0; m_ign = 0;
      return;
    end
    ign = 0;
    for (int k = 0; k < 16; k++) begin
      ncfg[k] = m_cfg[k];
      naddr[k] = m_addr[k];
    end
    if (we && wa >= 12'h3A0 && wa <= 12'h3A3) begin
      for (int b = 0; b < 4; b++) begin
        i = int'(wa - 12'h3A0) * 4 + b;
        if (i < NR) begin
          v = wd[8*b +: 8];
          bad = m_locked(i) || (!m_mml && !v[0] && v[1]) ||
                (m_mml && !m_rlb && v[7] && (v[2] || (!v[0] && v[1])));
          if (bad) ign = 1;
          else begin
            v = v & 8'h9F;
            if (GR >= 1 && v[4:3] == 2'd2) v[4:3] = 2'd0;
            ncfg[i] = v;
          end
        end
      end
    end
    if (we && wa >= 12'h3B0 && wa <= 12'h3BF) begin
      i = int'(wa - 12'h3B0);
      if (i < NR) begin
        bad = m_locked(i) || (i + 1 < NR && m_locked(i + 1) && m_cfg[i+1][4:3] == 2'd1);
        if (bad) ign = 1;
        else naddr[i] = wd;
      end
    end
    if (we && wa == 12'h747) begin
      any_l = 0;
      for (int k = 0; k < NR; k++) if (m_cfg[k][7]) any_l = 1;
      if (m_mml && !wd[0]) ign = 1;
      if (m_mmwp && !wd[1]) ign = 1;
      if (m_rlb || !any_l) m_rlb = wd[2];
      else if (wd[2]) ign = 1;
      m_mml = m_mml | wd[0];
      m_mmwp = m_mmwp | wd[1];
    end
    for (int k = 0; k < 16; k++) begin
      m_cfg[k] = ncfg[k];
      m_addr[k] = naddr[k];
    end
    m_ign = ign;
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic [127:0] ec;
    logic [543:0] ea;
    if (chk_on) begin
      for (int k = 0; k < 16; k++) begin
        ec[8*k +: 8] = m_cfg[k];
        ea[34*k +: 34] = {m_addr[k], 2'b00};
      end
      check("rdata", 544'(csr_rdata_o), 544'(model_read(csr_raddr_i)));
      check("wr_ignored", 544'(csr_wr_ignored_o), 544'(m_ign));
      check("pmp_cfg", 544'(csr_pmp_o.cfg), 544'(ec));
      check("pmp_addr", 544'(csr_pmp_o.addr), ea);
      check("pmp_mseccfg", 544'(csr_pmp_o.mseccfg), 544'({29'd0, m_rlb, m_mmwp, m_mml}));
    end
  end

  task automatic do_cycle(input logic rs, input logic we, input logic [11:0] wa,
                          input logic [31:0] wd, input logic [11:0] ra);
    rst_n = rs;
    csr_we_i = we;
    csr_waddr_i = wa;
    csr_wdata_i = wd;
    csr_raddr_i = ra;
    #1;
    pre_rd = csr_rdata_o;
    @(posedge clk);
    model_apply(rs, we, wa, wd);
    if (!rs) chk_on = 1;
    #1;
  endtask

  task automatic wr(input logic [11:0] wa, input logic [31:0] wd);
    do_cycle(1'b1, 1'b1, wa, wd, 12'h000);
  endtask

  task automatic rst();
    do_cycle(1'b0, 1'b0, 12'h000, 32'h0, 12'h000);
  endtask

  task automatic rd_lit(input string nm, input logic [11:0] a, input logic [31:0] exp);
    csr_we_i = 1'b0;
    csr_raddr_i = a;
    #1;
    check(nm, 544'(csr_rdata_o), 544'(exp));
  endtask

  task automatic ign_lit(input string nm, input logic exp);
    check(nm, 544'(csr_wr_ignored_o), 544'(exp));
  endtask

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 5))
      0, 1:    return 12'h3A0 + 12'($urandom_range(0, 3));
      2, 3:    return 12'h3B0 + 12'($urandom_range(0, 15));
      4:       return ($urandom_range(0, 1) != 0) ? 12'h747 : 12'h757;
      default: return 12'($urandom);
    endcase
  endfunction

  initial begin
    logic        rs, we;
    logic [11:0] wa, ra;
    logic [31:0] wd;

    rst();
    ign_lit("rst_ign", 1'b0);
    rd_lit("rst_cfg0", 12'h3A0, 32'h0);
    rd_lit("rst_mseccfg", 12'h747, 32'h0);
    do_cycle(1'b1, 1'b0, 12'h000, 32'h0, 12'h000);
    ign_lit("ign_after_rst", 1'b0);

    // Locked entry rejects a later cfg write
    wr(12'h3A0, 32'h0000_009F);
    ign_lit("lock_wr_ign", 1'b0);
    rd_lit("cfg0_lock", 12'h3A0, 32'h0000_009F);
    wr(12'h3A0, 32'h0000_0000);
    ign_lit("locked_ign_pulse", 1'b1);
    rd_lit("cfg0_kept", 12'h3A0, 32'h0000_009F);
    do_cycle(1'b1, 1'b0, 12'h000, 32'h0, 12'h000);
    ign_lit("ign_one_cycle", 1'b0);

    // Locked TOR entry 1 freezes pmpaddr0 and pmpaddr1
    rst();
    wr(12'h3A0, 32'h0000_8800);
    wr(12'h3B0, 32'h0000_1234);
    ign_lit("tor_addr0_ign", 1'b1);
    rd_lit("tor_addr0", 12'h3B0, 32'h0);
    wr(12'h3B1, 32'h0000_0055);
    ign_lit("tor_addr1_ign", 1'b1);
    rd_lit("tor_addr1", 12'h3B1, 32'h0);
    rd_lit("tor_cfg", 12'h3A0, 32'h0000_8800);

    // Rule-locking bypass
    rst();
    wr(12'h747, 32'h4);
    rd_lit("rlb_set", 12'h747, 32'h4);
    wr(12'h3A0, 32'h9F);
    wr(12'h3A0, 32'h00);
    rd_lit("rlb_cfg_cleared", 12'h3A0, 32'h0);
    wr(12'h747, 32'h0);
    rd_lit("rlb_clear", 12'h747, 32'h0);
    wr(12'h3A0, 32'h9F);
    wr(12'h747, 32'h4);
    ign_lit("rlb_blocked_ign", 1'b1);
    rd_lit("rlb_blocked", 12'h747, 32'h0);

    // Shared encoding and sticky MML
    rst();
    wr(12'h3A0, 32'h02);
    ign_lit("rw01_ign", 1'b1);
    rd_lit("rw01_nomml", 12'h3A0, 32'h0);
    wr(12'h747, 32'h1);
    rd_lit("mml_set", 12'h747, 32'h1);
    wr(12'h3A0, 32'h02);
    rd_lit("rw01_mml", 12'h3A0, 32'h02);
    wr(12'h747, 32'h0);
    rd_lit("mml_sticky", 12'h747, 32'h1);

    // Granularity read-back and NA4 folding
    rst();
    wr(12'h3B0, 32'hFFFF_FFF0);
    wr(12'h3A0, 32'h18);
    rd_lit("napot_rd", 12'h3B0, 32'hFFFF_FFF1);
    wr(12'h3A0, 32'h08);
    rd_lit("tor_rd", 12'h3B0, 32'hFFFF_FFF0);
    wr(12'h3A0, 32'h10);
    rd_lit("na4_off", 12'h3A0, 32'h0);

    // Same-cycle read returns pre-write value; unimplemented space reads 0
    do_cycle(1'b1, 1'b1, 12'h3B2, 32'h0000_ABCD, 12'h3B2);
    check("same_cycle_rd", 544'(pre_rd), 544'(32'h0));
    rd_lit("addr2_off_rd", 12'h3B2, 32'h0000_ABCC);
    wr(12'h3B5, 32'h1234);
    rd_lit("unimpl_addr", 12'h3B5, 32'h0);
    wr(12'h757, 32'h7);
    rd_lit("mseccfgh", 12'h757, 32'h0);
    rd_lit("bad_addr", 12'h123, 32'h0);

    // Reset beats a coincident write
    do_cycle(1'b0, 1'b1, 12'h3A0, 32'h9F, 12'h3A0);
    ign_lit("rst_wr_ign", 1'b0);
    rd_lit("rst_wr_cfg0", 12'h3A0, 32'h0);
    do_cycle(1'b1, 1'b0, 12'h000, 32'h0, 12'h3A0);
    ign_lit("rst_wr_ign2", 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      rs = ($urandom_range(0, 63) != 0);
      we = ($urandom_range(0, 3) != 0);
      wa = pick_addr();
      ra = pick_addr();
      wd = $urandom;
      if (wa >= 12'h3A0 && wa <= 12'h3A3 && $urandom_range(0, 7) != 0) wd &= 32'h7F7F_7F7F;
      if (wa == 12'h747 && $urandom_range(0, 1) != 0) wd &= 32'h7;
      do_cycle(rs, we, wa, wd, ra);
    end
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40s_pmp_csr.md
CV32E40S_PMP_CSR -- requirements
Module: cv32e40s_pmp_csr

Interface
REQ-001 SHALL have parameter PMP_GRANULARITY, default 0: NAPOT granule is 2^(G+2) bytes; legal range 0..29.
REQ-002 SHALL have parameter PMP_NUM_REGIONS, default 0: implemented entries; legal range 0..16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port csr_we_i  input  1  write strobe, one write per cycle.
REQ-006 SHALL have port csr_waddr_i  input  12  CSR write address.
REQ-007 SHALL have port csr_wdata_i  input  32  CSR write data.
REQ-008 SHALL have port csr_raddr_i  input  12  CSR read address.
REQ-009 SHALL have port csr_rdata_o  output  32  read data, combinational from current state.
REQ-010 SHALL have port csr_wr_ignored_o  output  1  registered pulse: previous-cycle write was fully or partly rejected.
REQ-011 SHALL have port csr_pmp_o  output  pmp_csr_t  cfg, addr and mseccfg fields feeding the PMP checker.

Function
REQ-012 SHALL decode pmpcfg0..3 (0x3A0..0x3A3), pmpaddr0..15 (0x3B0..0x3BF), mseccfg (0x747), mseccfgh (0x757).
REQ-013 SHALL apply writes at the clock edge where csr_we_i=1; new values visible on csr_pmp_o and csr_rdata_o from the next cycle.
REQ-014 SHALL, on read and write to the same address in one cycle, return the pre-write value.
REQ-015 SHALL lay out each pmpcfg byte as L[7], reserved[6:5] (read 0), A[4:3], X[2], W[1], R[0].
REQ-016 SHALL evaluate the four bytes of a pmpcfg write independently, each against pre-write state.
REQ-017 SHALL treat entry i as locked when cfg[i].L=1 and mseccfg.RLB=0.
REQ-018 SHALL ignore cfg writes to locked entries and pmpaddr[i] writes when entry i is locked, or when entry i+1 is locked with A=TOR.
REQ-019 SHALL ignore a cfg byte with R=0,W=1 while MML=0.
REQ-020 SHALL, while MML=1 and RLB=0, ignore a cfg byte with L=1 that encodes M-mode-executable (X=1, not R=0/W=1) or shared (R=0,W=1) permissions.
REQ-021 SHALL store A=NA4 as A=OFF when PMP_GRANULARITY>=1.
REQ-022 SHALL hold mseccfg.MML and mseccfg.MMWP sticky: writes can set them, only reset clears them.
REQ-023 SHALL accept writes to mseccfg.RLB only if RLB is currently 1 or no entry has L=1; other RLB writes are ignored.
REQ-024 SHALL store pmpaddr as 32 bits and drive csr_pmp_o.addr[i] = {pmpaddr[i], 2'b00} (34 bits).
REQ-025 SHALL, for G>=1, read pmpaddr bits [G-2:0] as 1 when A=NAPOT and bits [G-1:0] as 0 when A=OFF/TOR.
REQ-026 SHALL read 0 and ignore writes for unimplemented entries, mseccfgh and reserved bits.
REQ-027 SHALL drive csr_rdata_o=0 for addresses outside REQ-012.
REQ-028 SHALL pulse csr_wr_ignored_o for one cycle after any write with at least one field rejected by REQ-018..REQ-023; 0 otherwise.
REQ-029 SHALL, with PMP_NUM_REGIONS=0, tie every cfg/addr output to 0 and keep mseccfg functional.

Reset
REQ-030 SHALL, on rising clk with rst_n=0, clear every cfg byte (A=OFF, L=0), every pmpaddr, MML, MMWP and RLB.
REQ-031 SHALL drive csr_wr_ignored_o=0 during and in the first cycle after reset.
REQ-032 SHALL give reset priority over a coincident write; that write is lost.

Structure
REQ-033 SHALL take pmp_csr_t, the PMP_MODE_* encodings, CSR address constants and PMP_MAX_REGIONS=16 from cv32e40s_pkg.
REQ-034 SHALL define a pmpcfg byte struct in cv32e40s_pkg.
REQ-035 SHALL place the per-byte legalisation of REQ-019..REQ-021 in one sub-module, cv32e40s_pmp_cfg_legalize, instantiated per entry.

Verification
REQ-036 SHALL cover: PMP_NUM_REGIONS=4, write 0x3A0=0x0000_009F then 0x3A0=0x0000_0000 -> cfg0 reads 0x9F; second write ignored; csr_wr_ignored_o pulses.
REQ-037 SHALL cover: cfg1=0x88 (L, TOR), write pmpaddr0=0x1234 -> pmpaddr0 unchanged; pmpaddr1 write also ignored.
REQ-038 SHALL cover: write mseccfg=0x4 (RLB), then cfg0=0x9F, then cfg0=0x00 -> cfg0 becomes 0x00; then RLB=0 write sticks; a later RLB=1 write is ignored.
REQ-039 SHALL cover: MML=0, write cfg byte 0x02 -> ignored; set MML=1, write 0x02 -> stored; write mseccfg=0 -> MML stays 1.
REQ-040 SHALL cover: G=2, pmpaddr0=0xFFFF_FFF0 with A=NAPOT -> reads 0xFFFF_FFF1; set A=TOR -> reads 0xFFFF_FFF0; write NA4 -> A reads OFF.
REQ-041 SHALL cover: write cfg0=0x9F with rst_n=0 in the same cycle -> cfg0 reads 0 afterwards and csr_wr_ignored_o stays 0.
